// File: rtl/cpu_pkg.sv
// Shared CPU types: default bus widths, arbiter FSM
// state encodings and the RAM control bundle.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR1  = 3'd2,
    S_WR2  = 3'd3,
    S_WR3  = 3'd4,
    S_WR4  = 3'd5,
    S_ACK  = 3'd6
  } state_t;

  typedef struct packed {
    logic cs;
    logic we;
    logic oe;
  } ram_ctl_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Two requester ports plus the RAM side of the arbiter.
// slave: arbiter view; master: requester/RAM view.
interface mem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        grant;
  logic              ram_cs;
  logic              ram_we;
  logic              ram_oe;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  ram_rdata,
    output ack0, ack1, rdata, grant,
    output ram_cs, ram_we, ram_oe,
    output ram_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output ram_rdata,
    input  ack0, ack1, rdata, grant,
    input  ram_cs, ram_we, ram_oe,
    input  ram_addr, ram_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; last=1 means port 1 won
// last time. Ports: req[1:0] in, last in, win[1:0] out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = '0;
    unique case (1'b1)
      (req[0] & (~req[1] | last)):  win = 2'b01;
      (req[1] & (~req[0] | ~last)): win = 2'b10;
      default:                      win = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (port 0) and loader (port 1) onto one RAM.
// Ports: clk, rst_n, bus (mem_arbiter_if.slave).
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  ram_ctl_t          ctl_q, ctl_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        win;

  rr_arb2 u_arb (
    .req  ({bus.req1, bus.req0}),
    .last (last_q),
    .win  (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ctl_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ctl_q   <= ctl_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|win) begin
          grant_d = win;
          last_d  = win[1];
          addr_d  = win[1] ? bus.addr1 : bus.addr0;
          wdata_d = win[1] ? bus.wdata1 : bus.wdata0;
          if (win[1] ? bus.we1 : bus.we0)
            state_d = S_WR1;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        rdata_d = bus.ram_rdata;
        state_d = S_ACK;
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: state_d = S_WR4;
      S_WR4: state_d = S_ACK;
      S_ACK: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they
  // come straight from flops and line up with state_q.
  always_comb begin
    ctl_d = '0;
    ack_d = '0;
    unique case (state_d)
      S_RD:    ctl_d = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
      S_WR1:   ctl_d = '{cs: 1'b1, we: 1'b1, oe: 1'b0};
      S_WR2:   ctl_d = '{cs: 1'b0, we: 1'b1, oe: 1'b0};
      S_WR3:   ctl_d = '{cs: 1'b1, we: 1'b1, oe: 1'b0};
      S_WR4:   ctl_d = '{cs: 1'b0, we: 1'b1, oe: 1'b0};
      S_ACK:   ack_d = grant_d;
      default: ctl_d = '0;
    endcase
  end

  assign bus.ram_cs    = ctl_q.cs;
  assign bus.ram_we    = ctl_q.we;
  assign bus.ram_oe    = ctl_q.oe;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.grant     = grant_q;
  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, write, ties,
// reset abort, back-to-back and request changes.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag,
                      input logic [2:0] ctl,
                      input logic [1:0] ack,
                      input logic [1:0] gnt);
    tick();
    chk({tag, ".ctl"},
        64'({bus.ram_cs, bus.ram_we, bus.ram_oe}),
        64'(ctl));
    chk({tag, ".ack"}, 64'({bus.ack1, bus.ack0}), 64'(ack));
    chk({tag, ".gnt"}, 64'(bus.grant), 64'(gnt));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl",
          64'({bus.ack0 & bus.ack1, bus.ram_we & bus.ram_oe}),
          64'(0));
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    bus.ram_rdata = '0;
    repeat (2) tick();
    chk("rst.ctl",
        64'({bus.ram_cs, bus.ram_we, bus.ram_oe,
             bus.ack1, bus.ack0, bus.grant}),
        64'(0));
    chk("rst.addr", 64'(bus.ram_addr), 64'(0));
    chk("rst.wdata", bus.ram_wdata, 64'(0));
    chk("rst.rdata", bus.rdata, 64'(0));
    rst_n = 1'b1;
    step("idle0", 3'b000, 2'b00, 2'b00);

    // single read, addr0 changed mid-transaction
    bus.ram_rdata = 64'hDEADBEEF_00000001;
    bus.req0 = 1'b1;
    bus.we0 = 1'b0;
    bus.addr0 = 32'h10;
    step("rd.rd", 3'b101, 2'b00, 2'b01);
    chk("rd.addr", 64'(bus.ram_addr), 64'h10);
    bus.addr0 = 32'h30;
    step("rd.ack", 3'b000, 2'b01, 2'b01);
    chk("rd.addr2", 64'(bus.ram_addr), 64'h10);
    chk("rd.rdata", bus.rdata, 64'hDEADBEEF_00000001);
    bus.req0 = 1'b0;
    step("rd.idle", 3'b000, 2'b00, 2'b00);

    // single write from port 1
    bus.req1 = 1'b1;
    bus.we1 = 1'b1;
    bus.addr1 = 32'h20;
    bus.wdata1 = 64'h55;
    step("wr.1", 3'b110, 2'b00, 2'b10);
    chk("wr.addr", 64'(bus.ram_addr), 64'h20);
    chk("wr.wdata", bus.ram_wdata, 64'h55);
    step("wr.2", 3'b010, 2'b00, 2'b10);
    step("wr.3", 3'b110, 2'b00, 2'b10);
    step("wr.4", 3'b010, 2'b00, 2'b10);
    chk("wr.addr4", 64'(bus.ram_addr), 64'h20);
    chk("wr.wdata4", bus.ram_wdata, 64'h55);
    step("wr.ack", 3'b000, 2'b10, 2'b10);
    bus.req1 = 1'b0;
    step("wr.idle", 3'b000, 2'b00, 2'b00);

    // tie straight after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;
    bus.addr0 = 32'h100;
    bus.addr1 = 32'h200;
    bus.ram_rdata = 64'h1111;
    step("tie.rd0", 3'b101, 2'b00, 2'b01);
    chk("tie.addr0", 64'(bus.ram_addr), 64'h100);
    step("tie.ack0", 3'b000, 2'b01, 2'b01);
    bus.req0 = 1'b0;
    step("tie.idle", 3'b000, 2'b00, 2'b00);
    step("tie.rd1", 3'b101, 2'b00, 2'b10);
    chk("tie.addr1", 64'(bus.ram_addr), 64'h200);
    step("tie.ack1", 3'b000, 2'b10, 2'b10);
    bus.req0 = 1'b1;
    step("tie.idle2", 3'b000, 2'b00, 2'b00);
    step("tie.rd0b", 3'b101, 2'b00, 2'b01);
    step("tie.ack0b", 3'b000, 2'b01, 2'b01);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step("tie.idle3", 3'b000, 2'b00, 2'b00);

    // reset during WR3, then full restart
    bus.req1 = 1'b1;
    bus.we1 = 1'b1;
    bus.addr1 = 32'h44;
    bus.wdata1 = 64'h99;
    step("ra.1", 3'b110, 2'b00, 2'b10);
    step("ra.2", 3'b010, 2'b00, 2'b10);
    step("ra.3", 3'b110, 2'b00, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra.async",
        64'({bus.ram_cs, bus.ram_we, bus.ram_oe,
             bus.ack1, bus.ack0, bus.grant}),
        64'(0));
    chk("ra.addr", 64'(bus.ram_addr), 64'(0));
    chk("ra.wdata", bus.ram_wdata, 64'(0));
    chk("ra.rdata", bus.rdata, 64'(0));
    step("ra.hold", 3'b000, 2'b00, 2'b00);
    rst_n = 1'b1;
    step("rb.1", 3'b110, 2'b00, 2'b10);
    chk("rb.addr", 64'(bus.ram_addr), 64'h44);
    step("rb.2", 3'b010, 2'b00, 2'b10);
    step("rb.3", 3'b110, 2'b00, 2'b10);
    step("rb.4", 3'b010, 2'b00, 2'b10);
    step("rb.ack", 3'b000, 2'b10, 2'b10);
    chk("rb.wdata", bus.ram_wdata, 64'h99);
    bus.req1 = 1'b0;
    step("rb.idle", 3'b000, 2'b00, 2'b00);

    // back-to-back: p0 write, p1 read, p0 read
    bus.req0 = 1'b1;
    bus.we0 = 1'b1;
    bus.addr0 = 32'h60;
    bus.wdata0 = 64'hAA;
    bus.req1 = 1'b1;
    bus.we1 = 1'b0;
    bus.addr1 = 32'h70;
    bus.ram_rdata = 64'h2222;
    step("bb.w1", 3'b110, 2'b00, 2'b01);
    chk("bb.waddr", 64'(bus.ram_addr), 64'h60);
    chk("bb.wdata", bus.ram_wdata, 64'hAA);
    step("bb.w2", 3'b010, 2'b00, 2'b01);
    step("bb.w3", 3'b110, 2'b00, 2'b01);
    step("bb.w4", 3'b010, 2'b00, 2'b01);
    step("bb.wack", 3'b000, 2'b01, 2'b01);
    bus.we0 = 1'b0;
    bus.addr0 = 32'h64;
    step("bb.idle", 3'b000, 2'b00, 2'b00);
    step("bb.r1", 3'b101, 2'b00, 2'b10);
    chk("bb.r1addr", 64'(bus.ram_addr), 64'h70);
    step("bb.r1ack", 3'b000, 2'b10, 2'b10);
    chk("bb.r1data", bus.rdata, 64'h2222);
    bus.req1 = 1'b0;
    bus.ram_rdata = 64'h3333;
    step("bb.idle2", 3'b000, 2'b00, 2'b00);
    step("bb.r0", 3'b101, 2'b00, 2'b01);
    chk("bb.r0addr", 64'(bus.ram_addr), 64'h64);
    step("bb.r0ack", 3'b000, 2'b01, 2'b01);
    chk("bb.r0data", bus.rdata, 64'h3333);
    bus.req0 = 1'b0;
    step("bb.idle3", 3'b000, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
